// File: rtl/point_referee.sv
// Point referee: watches ball position once per frame, awards points,
// sequences serve/play/point/match-over and gates the ball physics.
module point_referee #(
  parameter int X_W         = 10,
  parameter int LEFT_GOAL   = 0,
  parameter int RIGHT_GOAL  = 639,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic [X_W-1:0] ball_x,
  input  logic           start_btn,
  output logic           Score_P1_update,
  output logic           Score_P2_update,
  output logic           ball_reset,
  output logic           ball_run,
  output logic           serve_dir,
  output logic [6:0]     p1_score,
  output logic [6:0]     p2_score,
  output logic           game_over,
  output logic           winner
);

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'((SERVE_DELAY > 0) ? (SERVE_DELAY - 1) : 0);
  localparam logic             ZERO_DELAY = (SERVE_DELAY == 0) ? 1'b1 : 1'b0;
  localparam logic [X_W-1:0]   LEFT_X     = X_W'(LEFT_GOAL);
  localparam logic [X_W-1:0]   RIGHT_X    = X_W'(RIGHT_GOAL);
  localparam logic [6:0]       WIN_M1     = 7'(WIN_SCORE - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SERVE_WAIT = 3'd1,
    S_PLAY       = 3'd2,
    S_POINT      = 3'd3,
    S_OVER       = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_start_q;
  logic             r_scorer;      // 0 = P1 scored, 1 = P2 scored
  logic             r_launch;      // first SERVE_WAIT cycle after a start edge
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_p1;
  logic [6:0]       r_p2;
  logic             r_serve_dir;

  logic             w_start_edge;
  logic             w_goal_left;
  logic             w_goal_right;
  logic             w_delay_done;
  logic [6:0]       w_scorer_cnt;
  logic             w_win;

  function automatic logic [6:0] score_inc(input logic [6:0] s);
    score_inc = s + 7'd1;
  endfunction

  assign w_start_edge = start_btn & ~r_start_q;
  assign w_goal_left  = frame_tick & (ball_x <= LEFT_X);
  assign w_goal_right = frame_tick & (ball_x >= RIGHT_X);
  assign w_delay_done = ZERO_DELAY | (frame_tick & (r_cnt == DELAY_LAST));
  assign w_scorer_cnt = r_scorer ? r_p2 : r_p1;
  assign w_win        = (w_scorer_cnt == WIN_M1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) w_next = S_SERVE_WAIT;
        else              w_next = S_IDLE;
      end
      S_SERVE_WAIT: begin
        if (w_delay_done) w_next = S_PLAY;
        else              w_next = S_SERVE_WAIT;
      end
      S_PLAY: begin
        if (w_goal_left || w_goal_right) w_next = S_POINT;
        else                             w_next = S_PLAY;
      end
      S_POINT: begin
        if (w_win) w_next = S_OVER;
        else       w_next = S_SERVE_WAIT;
      end
      S_OVER:  w_next = S_OVER;
      default: w_next = S_IDLE;
    endcase
  end

  // Start-edge history and serve-launch flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_q <= start_btn;
      r_launch  <= 1'b0;
    end else begin
      r_start_q <= start_btn;
      r_launch  <= (r_state == S_IDLE) && w_start_edge;
    end
  end

  // Serve delay counter: runs only in SERVE_WAIT, cleared everywhere else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state != S_SERVE_WAIT) begin
      r_cnt <= '0;
    end else if (frame_tick) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Scorer flag: left goal has priority if both goal conditions hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scorer <= 1'b0;
    end else if ((r_state == S_PLAY) && w_goal_left) begin
      r_scorer <= 1'b1;
    end else if ((r_state == S_PLAY) && w_goal_right) begin
      r_scorer <= 1'b0;
    end else begin
      r_scorer <= r_scorer;
    end
  end

  // Scores and serve direction commit at the end of the POINT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1        <= 7'd0;
      r_p2        <= 7'd0;
      r_serve_dir <= 1'b1;
    end else if (r_state == S_POINT) begin
      r_serve_dir <= ~r_scorer;
      if (r_scorer) begin
        r_p1 <= r_p1;
        r_p2 <= score_inc(r_p2);
      end else begin
        r_p1 <= score_inc(r_p1);
        r_p2 <= r_p2;
      end
    end else begin
      r_p1        <= r_p1;
      r_p2        <= r_p2;
      r_serve_dir <= r_serve_dir;
    end
  end

  // Moore output decode from registered state and flags
  always_comb begin
    Score_P1_update = 1'b0;
    Score_P2_update = 1'b0;
    ball_reset      = r_launch;
    ball_run        = 1'b0;
    game_over       = 1'b0;
    winner          = 1'b0;
    case (r_state)
      S_PLAY: ball_run = 1'b1;
      S_POINT: begin
        ball_reset      = 1'b1;
        Score_P1_update = ~r_scorer;
        Score_P2_update = r_scorer;
      end
      S_OVER: begin
        game_over = 1'b1;
        winner    = r_scorer;
      end
      default: ball_run = 1'b0;
    endcase
  end

  assign serve_dir = r_serve_dir;
  assign p1_score  = r_p1;
  assign p2_score  = r_p2;

endmodule

// File: tb/tb_point_referee.sv
// Scoreboard bench for point_referee (WIN_SCORE=3, SERVE_DELAY=3):
// stimulus queues expected pulse events, a monitor pops them as they appear.
module tb_point_referee;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [9:0] ball_x;
  logic       start_btn;
  logic       Score_P1_update;
  logic       Score_P2_update;
  logic       ball_reset;
  logic       ball_run;
  logic       serve_dir;
  logic [6:0] p1_score;
  logic [6:0] p2_score;
  logic       game_over;
  logic       winner;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic p1u;
    logic p2u;
    logic br;
  } ev_t;

  ev_t exp_q[$];

  point_referee #(
    .X_W(10), .LEFT_GOAL(0), .RIGHT_GOAL(639), .WIN_SCORE(3), .SERVE_DELAY(3)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .ball_x(ball_x),
    .start_btn(start_btn), .Score_P1_update(Score_P1_update),
    .Score_P2_update(Score_P2_update), .ball_reset(ball_reset),
    .ball_run(ball_run), .serve_dir(serve_dir), .p1_score(p1_score),
    .p2_score(p2_score), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Monitor: every pulse-output cycle must match the next queued event
  initial begin
    ev_t got;
    ev_t e;
    forever begin
      @(negedge clk);
      got = '{Score_P1_update, Score_P2_update, ball_reset};
      if (got != 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got p1u=%0b p2u=%0b br=%0b required none at %0t",
                   got.p1u, got.p2u, got.br, $time);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL event got p1u=%0b p2u=%0b br=%0b required p1u=%0b p2u=%0b br=%0b at %0t",
                     got.p1u, got.p2u, got.br, e.p1u, e.p2u, e.br, $time);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_match();
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    exp_q.push_back('{1'b0, 1'b0, 1'b1});
    step();
    chk("launch_run", ball_run, 0);
  endtask

  task automatic serve();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_run", ball_run, 0);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("serve_run", ball_run, (i == 2) ? 1 : 0);
    end
  endtask

  // Goal on a frame tick; leaves the bench one cycle after POINT
  task automatic goal(input logic [9:0] x, input logic p2);
    ball_x     = x;
    frame_tick = 1'b1;
    exp_q.push_back('{~p2, p2, 1'b1});
    step();
    frame_tick = 1'b0;
    ball_x     = 10'd320;
    chk("point_run", ball_run, 0);
    step();
  endtask

  initial begin
    rst        = 1'b1;
    start_btn  = 1'b1;
    frame_tick = 1'b0;
    ball_x     = 10'd320;

    // 1: button held through reset gives no start
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("rst_run", ball_run, 0);
    chk("rst_reset", ball_reset, 0);
    chk("rst_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_dir", serve_dir, 1);
    chk("rst_p1", p1_score, 0);
    chk("rst_p2", p2_score, 0);

    // 2: start and serve delay
    start_match();
    serve();

    // 3: left goal, P2 scores
    goal(10'd0, 1'b1);
    chk("p2_after_goal", p2_score, 1);
    chk("dir_after_p2", serve_dir, 0);
    chk("run_after_p2", ball_run, 0);
    serve();

    // 4: right goal ignored without tick, then scored with tick
    ball_x = 10'd700;
    step();
    step();
    chk("no_tick_p1", p1_score, 0);
    chk("no_tick_run", ball_run, 1);
    goal(10'd700, 1'b0);
    chk("p1_after_goal", p1_score, 1);
    chk("dir_after_p1", serve_dir, 1);

    // 5: P1 reaches WIN_SCORE=3
    serve();
    goal(10'd639, 1'b0);
    chk("p1_two", p1_score, 2);
    chk("not_over", game_over, 0);
    serve();
    goal(10'd639, 1'b0);
    chk("p1_win", p1_score, 3);
    chk("over", game_over, 1);
    chk("winner", winner, 0);
    chk("over_run", ball_run, 0);
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    ball_x    = 10'd0;
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
    ball_x = 10'd320;
    chk("over_hold", game_over, 1);
    chk("over_p2", p2_score, 1);
    chk("over_p1", p1_score, 3);

    // 6a: reset in PLAY on a goal tick
    rst       = 1'b1;
    start_btn = 1'b0;
    step();
    rst = 1'b0;
    chk("rst2_over", game_over, 0);
    chk("rst2_p1", p1_score, 0);
    start_match();
    serve();
    rst        = 1'b1;
    ball_x     = 10'd0;
    frame_tick = 1'b1;
    step();
    rst        = 1'b0;
    frame_tick = 1'b0;
    ball_x     = 10'd320;
    chk("rst_play_run", ball_run, 0);
    chk("rst_play_p2", p2_score, 0);

    // 6b: reset on the POINT cycle
    start_match();
    serve();
    ball_x     = 10'd0;
    frame_tick = 1'b1;
    exp_q.push_back('{1'b0, 1'b1, 1'b1});
    step();
    frame_tick = 1'b0;
    ball_x     = 10'd320;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_point_p2", p2_score, 0);
    chk("rst_point_dir", serve_dir, 1);
    chk("rst_point_run", ball_run, 0);
    step();
    step();
    step();
    chk("pending_events", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/point_referee.md
Name: point_referee

Overview:
- Game-rule controller directly upstream of the two-player score display counter.
- Watches ball position once per video frame and decides when a goal is scored.
- Emits the one-cycle Score_P1_update / Score_P2_update pulses that the display counter consumes, and sequences serve, play, point and match-over.
- Gates ball motion for the ball physics block.

Parameters:
- X_W, 10, ball X coordinate width.
- LEFT_GOAL, 0, ball_x <= this value is a goal against P1 (P2 scores).
- RIGHT_GOAL, 639, ball_x >= this value is a goal against P2 (P1 scores).
- WIN_SCORE, 7, points that end the match; legal range 1..99 (two display digits).
- SERVE_DELAY, 60, frame_ticks to wait before each serve; 0 is legal.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- ball_x  in  X_W  current ball X position, stable while frame_tick is high.
- start_btn  in  1  debounced start level.
- Score_P1_update  out  1  one-cycle pulse when P1 scores.
- Score_P2_update  out  1  one-cycle pulse when P2 scores.
- ball_reset  out  1  one-cycle pulse to recentre the ball.
- ball_run  out  1  ball is allowed to move.
- serve_dir  out  1  0 = serve toward P1 (left), 1 = toward P2 (right).
- p1_score  out  7  binary P1 score.
- p2_score  out  7  binary P2 score.
- game_over  out  1  match finished.
- winner  out  1  0 = P1, 1 = P2; valid only when game_over = 1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; p1_score=p2_score=0.
  - serve_dir=1; delay counter cleared.
  - All pulse outputs, ball_run, game_over and winner are 0.
  - start_q loads start_btn during reset, so a button held through reset does not produce a start edge.
- Start edge: start_btn=1 and start_q=0; start_q <= start_btn every cycle.
- States: IDLE, SERVE_WAIT, PLAY, POINT, OVER. Outputs are Moore, decoded from registered state and registered scorer flag.
- IDLE:
  - ball_run=0.
  - Start edge -> SERVE_WAIT with ball_reset=1 for that transition cycle; delay counter cleared.
- SERVE_WAIT:
  - ball_run=0; the delay counter increments on each frame_tick.
  - On the cycle after the SERVE_DELAY-th frame_tick, go to PLAY.
  - If SERVE_DELAY=0, go to PLAY the next cycle regardless of frame_tick.
  - Goals are not evaluated.
- PLAY:
  - ball_run=1. Goals are evaluated only on cycles with frame_tick=1.
  - ball_x <= LEFT_GOAL: scorer=P2; go to POINT.
  - Otherwise ball_x >= RIGHT_GOAL: scorer=P1; go to POINT.
  - If both conditions hold (misconfigured parameters), the LEFT_GOAL check wins.
  - A goal condition without frame_tick is ignored.
- POINT (exactly one cycle):
  - ball_run=0 and ball_reset=1.
  - Exactly one of Score_P1_update / Score_P2_update is 1, per scorer.
  - The scorer's count increments at the end of the cycle; the new value is visible the next cycle.
  - serve_dir is set toward the conceding player: P1 scored -> 1, P2 scored -> 0.
  - Next state: if (scorer count + 1) == WIN_SCORE -> OVER with winner=scorer; else SERVE_WAIT with the delay counter cleared.
- Goal latency: frame_tick goal at cycle N -> update pulse and ball_reset at N+1 -> score visible and game_over (if any) at N+2.
- OVER:
  - game_over=1, ball_run=0; start edges and goals are ignored.
  - Scores hold; the downstream display counter clears only on rst, so leaving OVER requires rst.
- Score width: 7 bits; a score can never exceed WIN_SCORE, so it never wraps.
- Reset mid-operation (any state, including POINT): a pending update pulse is not emitted; the block returns to IDLE next cycle.
- Outputs never glitch: all outputs are decoded from registered state and registered scorer flag.

Test Plan:
1. rst=1 for 2 cycles with start_btn=1, then release rst keeping start_btn=1 -> stays IDLE; all outputs 0, serve_dir=1; no ball_reset.
2. SERVE_DELAY=3: start_btn 0->1 -> ball_reset pulse one cycle; ball_run=0 through 3 frame_ticks; ball_run=1 on the cycle after the third tick.
3. PLAY, ball_x=0 with frame_tick -> next cycle Score_P2_update=1 for exactly one cycle and ball_reset=1; following cycle p2_score=1, serve_dir=0, state SERVE_WAIT.
4. PLAY, ball_x=700 without frame_tick -> no pulse. Same value with frame_tick -> Score_P1_update pulse, p1_score increments, serve_dir=1.
5. WIN_SCORE=3, P1 scores three times -> third pulse followed by game_over=1, winner=0, p1_score=3; later start edges and ball_x=0 frame_ticks produce no pulses.
6. rst asserted during PLAY and on the POINT cycle -> next cycle IDLE, scores 0, no update pulse emitted after reset.
